// File: rtl/scan_addr_checker.sv
// rtl/scan_addr_checker.sv - recovers (x, y) indices from a 2D affine address stream and flags mismatches
module scan_addr_checker #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] offset,
    input  logic [WIDTH-1:0] x_max,
    input  logic [WIDTH-1:0] y_max,
    input  logic [WIDTH-1:0] x_stride,
    input  logic [WIDTH-1:0] y_stride,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_addr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic             out_last_x,
    output logic             out_last,
    output logic             out_err,
    output logic [WIDTH-1:0] err_count,
    output logic             busy
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] offset_r;
    logic [WIDTH-1:0] x_max_r;
    logic [WIDTH-1:0] y_max_r;
    logic [WIDTH-1:0] x_stride_r;
    logic [WIDTH-1:0] y_stride_r;
    logic [WIDTH-1:0] x_cnt;
    logic [WIDTH-1:0] y_cnt;
    logic [WIDTH-1:0] acc;
    logic             frame_taken;

    logic             accept;
    logic             last_x;
    logic             last_y;
    logic             mismatch;

    // Extents are decremented modulo 2^WIDTH, so an extent of 0 spans the full range.
    assign last_x   = (x_cnt == x_max_r - WIDTH'(1));
    assign last_y   = (y_cnt == y_max_r - WIDTH'(1));
    assign mismatch = (in_addr != offset_r + acc);
    assign in_ready = (state == RUN) && !frame_taken && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            offset_r    <= '0;
            x_max_r     <= '0;
            y_max_r     <= '0;
            x_stride_r  <= '0;
            y_stride_r  <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            acc         <= '0;
            frame_taken <= 1'b0;
            out_valid   <= 1'b0;
            out_x       <= '0;
            out_y       <= '0;
            out_last_x  <= 1'b0;
            out_last    <= 1'b0;
            out_err     <= 1'b0;
            err_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RUN;
                        offset_r    <= offset;
                        x_max_r     <= x_max;
                        y_max_r     <= y_max;
                        x_stride_r  <= x_stride;
                        y_stride_r  <= y_stride;
                        x_cnt       <= '0;
                        y_cnt       <= '0;
                        acc         <= '0;
                        err_count   <= '0;
                        frame_taken <= 1'b0;
                    end
                end
                RUN: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            state       <= IDLE;
                            frame_taken <= 1'b0;
                        end
                    end
                    // frame_taken blocks new beats, so an accept never coincides with the final handoff.
                    if (accept) begin
                        out_valid  <= 1'b1;
                        out_x      <= x_cnt;
                        out_y      <= y_cnt;
                        out_last_x <= last_x;
                        out_last   <= last_x && last_y;
                        out_err    <= mismatch;
                        if (mismatch && (err_count != '1))
                            err_count <= err_count + WIDTH'(1);
                        if (last_x && last_y)
                            frame_taken <= 1'b1;
                        if (last_x) begin
                            acc   <= acc + y_stride_r;
                            x_cnt <= '0;
                            y_cnt <= last_y ? '0 : y_cnt + WIDTH'(1);
                        end else begin
                            acc   <= acc + x_stride_r;
                            x_cnt <= x_cnt + WIDTH'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_addr_checker.sv
// tb/tb_scan_addr_checker.sv - scoreboard bench for scan_addr_checker against a closed-form address model
module tb_scan_addr_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] offset = '0, x_max = '0, y_max = '0, x_stride = '0, y_stride = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_addr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_x, out_y, err_count;
    logic        out_last_x, out_last, out_err, busy;

    scan_addr_checker #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .offset(offset), .x_max(x_max), .y_max(y_max),
        .x_stride(x_stride), .y_stride(y_stride),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_last_x(out_last_x), .out_last(out_last),
        .out_err(out_err), .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        lx;
        logic        l;
        logic        err;
        logic [15:0] ecnt;
    } beat_t;

    beat_t       sb[$];
    logic [15:0] addr_list[$];
    int          compared = 0;
    int          mismatched = 0;
    int          ready_pct = 100;
    int          hold_cnt = 0;
    logic [15:0] model_errs;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Address of beat (x, y): every full row contributes (x_max-1) x-steps plus one y-step.
    function automatic logic [15:0] model_addr(input logic [15:0] off, xm, xs, ys, input int x, input int y);
        int unsigned row_step;
        row_step = (int'(xm) - 1) * int'(xs) + int'(ys);
        return 16'(int'(off) + y * row_step + x * int'(xs));
    endfunction

    always @(posedge clk) begin
        #1;
        if (hold_cnt > 0) begin
            out_ready = 1'b0;
            hold_cnt--;
        end else begin
            out_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    logic        prev_stall = 1'b0;
    logic [35:0] prev_fields;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_fields", {out_x, out_y, out_last_x, out_last, out_err, 1'b0}, prev_fields);
            end
            if (out_valid && !out_ready)
                chk("stall_in_ready", in_ready, 0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", out_valid, 0);
                end else begin
                    beat_t e;
                    e = sb.pop_front();
                    chk("out_x", out_x, e.x);
                    chk("out_y", out_y, e.y);
                    chk("out_last_x", out_last_x, e.lx);
                    chk("out_last", out_last, e.l);
                    chk("out_err", out_err, e.err);
                    chk("err_count", err_count, e.ecnt);
                end
            end
            prev_stall  = out_valid && !out_ready;
            prev_fields = {out_x, out_y, out_last_x, out_last, out_err, 1'b0};
        end
    end

    task automatic check_reset_state(input string name);
        @(negedge clk);
        chk(name, {out_valid, out_x, out_y, out_last_x, out_last, out_err, err_count, in_ready, busy}, 0);
    endtask

    task automatic run_frame(input logic [15:0] off, xm, ym, xs, ys,
                             input int corrupt_pct, input int in_pct,
                             input int abort_after, input int stall_at, input bit restart_mid);
        int  n, k, cyc;
        bit  rs_done, st_done;
        logic [15:0] ea;
        beat_t e;
        @(posedge clk); #1;
        offset = off; x_max = xm; y_max = ym; x_stride = xs; y_stride = ys; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        offset = 16'($urandom); x_max = 16'($urandom); y_max = 16'($urandom);
        chk("busy_after_start", busy, 1);
        n = int'(xm) * int'(ym);
        k = 0; cyc = 0; rs_done = 0; st_done = 0; model_errs = '0;
        while (k < n && k != abort_after) begin
            ea       = model_addr(off, xm, xs, ys, k % int'(xm), k / int'(xm));
            in_valid = ($urandom_range(0, 99) < in_pct);
            if (addr_list.size() > 0)
                in_addr = addr_list[k];
            else if ($urandom_range(0, 99) < corrupt_pct)
                in_addr = ea ^ (16'h1 << $urandom_range(0, 15));
            else
                in_addr = ea;
            start = 1'b0;
            if (restart_mid && k == 1 && !rs_done) begin
                rs_done = 1;
                start = 1'b1;
                offset = 16'($urandom); x_max = 16'd7; y_max = 16'd9; x_stride = 16'($urandom);
            end
            if (k == stall_at && !st_done) begin
                st_done = 1;
                hold_cnt = 3;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                e.x   = 16'(k % int'(xm));
                e.y   = 16'(k / int'(xm));
                e.lx  = (int'(e.x) == int'(xm) - 1);
                e.l   = e.lx && (int'(e.y) == int'(ym) - 1);
                e.err = (in_addr != ea);
                if (e.err && model_errs != 16'hFFFF)
                    model_errs++;
                e.ecnt = model_errs;
                sb.push_back(e);
                k++;
                cyc = 0;
            end else if (++cyc > 200) begin
                chk("accept_timeout", 1, 0);
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (k == abort_after) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            sb.delete();
            check_reset_state("abort_reset_state");
        end else begin
            cyc = 0;
            while (busy) begin
                @(negedge clk);
                if (++cyc > 500) begin
                    chk("idle_timeout", busy, 0);
                    break;
                end
            end
            @(negedge clk);
            chk("busy_end", busy, 0);
            chk("sb_drained", sb.size(), 0);
            chk("final_err_count", err_count, model_errs);
        end
        addr_list.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_state("reset_state");

        ready_pct = 100;
        for (int i = 0; i < 8; i++) addr_list.push_back(16'h100 + 16'(i));
        run_frame(16'h100, 16'd4, 16'd2, 16'd1, 16'd1, 0, 100, -1, -1, 0);

        run_frame(16'h0, 16'd3, 16'd2, 16'd2, 16'd10, 0, 100, -1, -1, 0);
        addr_list = '{16'd0, 16'd2, 16'd4, 16'd6, 16'd16, 16'd18};
        run_frame(16'h0, 16'd3, 16'd2, 16'd2, 16'd10, 0, 100, -1, -1, 0);
        chk("t2_err_count", err_count, 1);

        run_frame(16'h300, 16'd4, 16'd3, 16'd3, 16'd5, 10, 100, -1, 4, 0);
        run_frame(16'h20, 16'd1, 16'd3, 16'd4, 16'd7, 0, 100, -1, -1, 1);
        run_frame(16'd5, 16'd4, 16'd1, 16'hFFFF, 16'd0, 0, 100, -1, -1, 0);

        run_frame(16'h40, 16'd4, 16'd2, 16'd1, 16'd1, 50, 100, 3, -1, 0);
        run_frame(16'h40, 16'd4, 16'd2, 16'd1, 16'd1, 0, 100, -1, -1, 0);

        ready_pct = 70;
        for (int f = 0; f < 30; f++) begin
            run_frame(16'($urandom), 16'($urandom_range(1, 6)), 16'($urandom_range(1, 5)),
                      16'($urandom), 16'($urandom), 15, 70, -1,
                      (f % 5 == 0) ? 2 : -1, (f % 7 == 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
